rst_codec: RTL and testbench

RST_CODEC -- requirements
Module: rst_codec

---
 rtl/rst_codec.sv | 240 ++++++++++++++++++++++++
 tb/tb_rst_codec.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rst_codec.sv
`default_nettype none
// ============================================================================
// Module      : rst_codec
// Description : 6x6 label-substitution codec. The key FSM validates a
//               twelve-character key and installs row/column labels. Each
//               beat then encrypts a character to a label pair or decrypts a
//               label pair back to a character. Labels rotate after every
//               good beat.
// Revision    : 1.0 - initial release
// ============================================================================
module rst_codec #(
    parameter int ROT_STEP   = 1,
    parameter bit DECRYPT_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [95:0] key,
    input  logic        key_load,
    input  logic        mode,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic [1:0]  out_err,
    output logic        key_busy,
    output logic        key_ok,
    output logic        key_err
);

    typedef enum logic [1:0] {
        ST_NO_KEY = 2'd0,
        ST_CHECK  = 2'd1,
        ST_READY  = 2'd2
    } state_t;

    localparam logic [1:0] c_err_ok    = 2'd0;
    localparam logic [1:0] c_err_char  = 2'd1;
    localparam logic [1:0] c_err_nokey = 2'd2;

    // Fixed cell contents: 'a'..'z' then '0'..'9' in row-major order
    function automatic logic [7:0] cell_char(input int p);
        if (p < 26) begin
            return 8'(97 + p);
        end
        return 8'(48 + p - 26);
    endfunction

    state_t      r_state_q, w_state_d;
    logic [95:0] r_key_q, w_key_d;
    logic [3:0]  r_idx_q, w_idx_d;
    logic        r_key_err_q, w_key_err_d;
    logic [7:0]  r_row_q [6];
    logic [7:0]  w_row_d [6];
    logic [7:0]  r_col_q [6];
    logic [7:0]  w_col_d [6];
    logic        r_out_valid_q, w_out_valid_d;
    logic [15:0] r_out_data_q, w_out_data_d;
    logic [1:0]  r_out_err_q, w_out_err_d;

    logic [7:0]  w_k [16];
    logic [7:0]  w_cur;
    logic        w_alnum;
    logic        w_dup;
    logic        w_dec_mode;
    logic        w_accept;
    logic [7:0]  w_char;
    logic        w_enc_hit;
    logic [15:0] w_enc_data;
    logic [5:0]  w_row_hit;
    logic [5:0]  w_col_hit;
    logic [15:0] w_dec_data;
    logic [15:0] w_beat_data;
    logic [1:0]  w_beat_err;

    // Without the decrypt datapath every beat is treated as an encrypt
    if (DECRYPT_EN) begin : g_dec
        assign w_dec_mode = mode;
    end else begin : g_no_dec
        assign w_dec_mode = 1'b0;
    end

    assign in_ready  = (r_state_q != ST_CHECK) && (!r_out_valid_q || out_ready) && !key_load;
    assign w_accept  = in_valid && in_ready;
    assign out_valid = r_out_valid_q;
    assign out_data  = r_out_data_q;
    assign out_err   = r_out_err_q;
    assign key_busy  = (r_state_q == ST_CHECK);
    assign key_ok    = (r_state_q == ST_READY);
    assign key_err   = r_key_err_q;

    // Split the captured key into characters; slots 12..15 pad the index range
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            w_k[i] = 8'h00;
        end
        for (int i = 0; i < 12; i++) begin
            w_k[i] = r_key_q[8*(11-i) +: 8];
        end
    end

    // Validate the character at the current check index: alphanumeric and unseen so far
    always_comb begin
        w_cur   = w_k[r_idx_q];
        w_alnum = ((w_cur >= 8'h30) && (w_cur <= 8'h39)) ||
                  ((w_cur >= 8'h41) && (w_cur <= 8'h5A)) ||
                  ((w_cur >= 8'h61) && (w_cur <= 8'h7A));
        w_dup   = 1'b0;
        for (int j = 0; j < 12; j++) begin
            if ((4'(j) < r_idx_q) && (w_k[j] == w_cur)) begin
                w_dup = 1'b1;
            end
        end
    end

    // Per-beat lookup: encrypt searches the fixed cells, decrypt matches labels
    always_comb begin
        w_char = in_data[7:0];
        if ((w_char >= 8'h41) && (w_char <= 8'h5A)) begin
            w_char = w_char + 8'h20;
        end
        w_enc_hit  = 1'b0;
        w_enc_data = 16'h0000;
        w_row_hit  = 6'b0;
        w_col_hit  = 6'b0;
        w_dec_data = 16'h0000;
        for (int r = 0; r < 6; r++) begin
            w_row_hit[r] = (r_row_q[r] == in_data[15:8]);
            w_col_hit[r] = (r_col_q[r] == in_data[7:0]);
        end
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 6; c++) begin
                if (cell_char(6*r + c) == w_char) begin
                    w_enc_hit  = 1'b1;
                    w_enc_data = {r_row_q[r], r_col_q[c]};
                end
                if (w_row_hit[r] && w_col_hit[c]) begin
                    w_dec_data = {8'h00, cell_char(6*r + c)};
                end
            end
        end
        if (r_state_q != ST_READY) begin
            w_beat_err  = c_err_nokey;
            w_beat_data = 16'h0000;
        end else if (w_dec_mode) begin
            w_beat_err  = ((|w_row_hit) && (|w_col_hit)) ? c_err_ok : c_err_char;
            w_beat_data = ((|w_row_hit) && (|w_col_hit)) ? w_dec_data : 16'h0000;
        end else begin
            w_beat_err  = w_enc_hit ? c_err_ok : c_err_char;
            w_beat_data = w_enc_hit ? w_enc_data : 16'h0000;
        end
    end

    // Key FSM next state, label install and label rotation after good beats
    always_comb begin
        w_state_d   = r_state_q;
        w_key_d     = r_key_q;
        w_idx_d     = r_idx_q;
        w_key_err_d = 1'b0;
        w_row_d     = r_row_q;
        w_col_d     = r_col_q;
        if (key_load) begin
            w_key_d   = key;
            w_idx_d   = 4'd0;
            w_state_d = ST_CHECK;
            for (int i = 0; i < 6; i++) begin
                w_row_d[i] = 8'h00;
                w_col_d[i] = 8'h00;
            end
        end else begin
            case (r_state_q)
                ST_CHECK: begin
                    if (!w_alnum || w_dup) begin
                        w_key_err_d = 1'b1;
                        w_state_d   = ST_NO_KEY;
                    end else if (r_idx_q == 4'd11) begin
                        w_row_d   = '{w_k[0], w_k[10], w_k[2], w_k[8], w_k[4], w_k[6]};
                        w_col_d   = '{w_k[1], w_k[11], w_k[3], w_k[9], w_k[5], w_k[7]};
                        w_state_d = ST_READY;
                    end else begin
                        w_idx_d = r_idx_q + 4'd1;
                    end
                end
                ST_READY: begin
                    if (w_accept && (w_beat_err == c_err_ok)) begin
                        for (int i = 0; i < 6; i++) begin
                            w_row_d[i] = r_row_q[(i + 6 - ROT_STEP) % 6];
                            w_col_d[i] = r_col_q[(i + 6 - ROT_STEP) % 6];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Single-entry output register: load on accept, drain when the sink takes it
    always_comb begin
        w_out_valid_d = r_out_valid_q;
        w_out_data_d  = r_out_data_q;
        w_out_err_d   = r_out_err_q;
        if (w_accept) begin
            w_out_valid_d = 1'b1;
            w_out_data_d  = w_beat_data;
            w_out_err_d   = w_beat_err;
        end else if (out_ready) begin
            w_out_valid_d = 1'b0;
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q     <= ST_NO_KEY;
            r_key_q       <= '0;
            r_idx_q       <= '0;
            r_key_err_q   <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                r_row_q[i] <= 8'h00;
                r_col_q[i] <= 8'h00;
            end
            r_out_valid_q <= 1'b0;
            r_out_data_q  <= '0;
            r_out_err_q   <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_key_q       <= w_key_d;
            r_idx_q       <= w_idx_d;
            r_key_err_q   <= w_key_err_d;
            r_row_q       <= w_row_d;
            r_col_q       <= w_col_d;
            r_out_valid_q <= w_out_valid_d;
            r_out_data_q  <= w_out_data_d;
            r_out_err_q   <= w_out_err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rst_codec.sv
`default_nettype none
// ============================================================================
// Module      : tb_rst_codec
// Description : Directed self-checking bench for rst_codec. Instance 0 uses
//               ROT_STEP 1, instance 1 uses ROT_STEP 5.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rst_codec;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [95:0] key       [2];
    logic        key_load  [2];
    logic        mode      [2];
    logic        in_valid  [2];
    logic [15:0] in_data   [2];
    logic        out_ready [2];
    wire         in_ready  [2];
    wire         out_valid [2];
    wire  [15:0] out_data  [2];
    wire  [1:0]  out_err   [2];
    wire         key_busy  [2];
    wire         key_ok    [2];
    wire         key_err   [2];

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] m_row [2][6];
    logic [7:0] m_col [2][6];

    localparam logic [95:0] KEY_GOOD = "abcdefghijkl";
    localparam logic [95:0] KEY_BADC = "abcdefghi?kl";
    localparam logic [95:0] KEY_DUP  = "abcdabcdabcd";
    localparam logic [95:0] KEY_RT   = "Zy3Xw2Vu1Ts0";

    always #5 clk = ~clk;

    rst_codec #(.ROT_STEP(1), .DECRYPT_EN(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .key(key[0]), .key_load(key_load[0]), .mode(mode[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .out_err(out_err[0]), .key_busy(key_busy[0]), .key_ok(key_ok[0]), .key_err(key_err[0])
    );

    rst_codec #(.ROT_STEP(5), .DECRYPT_EN(1'b1)) u_dut5 (
        .clk(clk), .rst(rst), .key(key[1]), .key_load(key_load[1]), .mode(mode[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .out_err(out_err[1]), .key_busy(key_busy[1]), .key_ok(key_ok[1]), .key_err(key_err[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] fold(input logic [7:0] ch);
        if ((ch >= 8'h41) && (ch <= 8'h5A)) return ch + 8'h20;
        return ch;
    endfunction

    task automatic model_load(input int u, input logic [95:0] k);
        logic [7:0] kc [12];
        for (int i = 0; i < 12; i++) kc[i] = k[95-8*i -: 8];
        m_row[u] = '{kc[0], kc[10], kc[2], kc[8], kc[4], kc[6]};
        m_col[u] = '{kc[1], kc[11], kc[3], kc[9], kc[5], kc[7]};
    endtask

    // Reference encrypt of a valid character, followed by the label rotation
    task automatic model_enc(input int u, input logic [7:0] ch, output logic [15:0] d);
        logic [7:0] c;
        logic [7:0] tr [6];
        logic [7:0] tc [6];
        int p;
        int s;
        c = fold(ch);
        if ((c >= 8'h61) && (c <= 8'h7A)) p = int'(c) - 97;
        else                              p = 26 + int'(c) - 48;
        d = {m_row[u][p / 6], m_col[u][p % 6]};
        s = (u == 0) ? 1 : 5;
        for (int i = 0; i < 6; i++) begin
            tr[i] = m_row[u][(i + 6 - s) % 6];
            tc[i] = m_col[u][(i + 6 - s) % 6];
        end
        m_row[u] = tr;
        m_col[u] = tc;
    endtask

    task automatic load(input int u, input logic [95:0] k);
        key[u]      = k;
        key_load[u] = 1'b1;
        #1;
        chk("load_blocks_in", 32'(in_ready[u]), 32'd0);
        @(negedge clk);
        key_load[u] = 1'b0;
        chk("load_busy", 32'(key_busy[u]), 32'd1);
    endtask

    task automatic wait_key(input int u, output int ok_at, output int err_at);
        ok_at  = 0;
        err_at = 0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (key_ok[u] && (ok_at == 0))  ok_at  = i;
            if (key_err[u] && (err_at == 0)) err_at = i;
            if ((ok_at != 0) || (err_at != 0)) break;
        end
    endtask

    task automatic send(input int u, input logic m, input logic [15:0] d,
                        input logic [15:0] exp_d, input logic [1:0] exp_e, input string tag);
        mode[u]     = m;
        in_data[u]  = d;
        in_valid[u] = 1'b1;
        #1;
        chk({tag, "/rdy"}, 32'(in_ready[u]), 32'd1);
        @(negedge clk);
        in_valid[u] = 1'b0;
        chk({tag, "/vld"}, 32'(out_valid[u]), 32'd1);
        chk({tag, "/data"}, 32'(out_data[u]), 32'(exp_d));
        chk({tag, "/err"}, 32'(out_err[u]), 32'(exp_e));
    endtask

    task automatic round_trip(input int u, input logic [95:0] k);
        logic [7:0]  pt [6];
        logic [15:0] ct [6];
        logic [15:0] e;
        int ok_at;
        int err_at;
        pt = '{8'h48, 8'h69, 8'h39, 8'h7A, 8'h51, 8'h30};
        model_load(u, k);
        load(u, k);
        wait_key(u, ok_at, err_at);
        chk("rt_key_ok", 32'(ok_at), 32'd12);
        for (int i = 0; i < 6; i++) begin
            model_enc(u, pt[i], e);
            ct[i] = e;
            send(u, 1'b0, {8'h00, pt[i]}, e, 2'd0, "rt_enc");
        end
        load(u, k);
        wait_key(u, ok_at, err_at);
        chk("rt_rekey_ok", 32'(ok_at), 32'd12);
        for (int i = 0; i < 6; i++) begin
            send(u, 1'b1, ct[i], {8'h00, fold(pt[i])}, 2'd0, "rt_dec");
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ok_at;
        int err_at;
        int sent;
        int got;
        int cyc;
        logic [7:0]  stream [62];
        logic [15:0] expq [$];
        logic [15:0] e;
        logic        stall_prev;
        logic [15:0] held;

        for (int u = 0; u < 2; u++) begin
            key[u] = '0; key_load[u] = 1'b0; mode[u] = 1'b0;
            in_valid[u] = 1'b0; in_data[u] = '0; out_ready[u] = 1'b1;
        end

        // Reset values, before any clock edge
        #3;
        chk("rst_out_valid", 32'(out_valid[0]), 32'd0);
        chk("rst_out_data", 32'(out_data[0]), 32'd0);
        chk("rst_out_err", 32'(out_err[0]), 32'd0);
        chk("rst_key_ok", 32'(key_ok[0]), 32'd0);
        chk("rst_key_busy", 32'(key_busy[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic install and two encrypts with rotation
        load(0, KEY_GOOD);
        wait_key(0, ok_at, err_at);
        chk("good_key_ok_at", 32'(ok_at), 32'd12);
        chk("good_key_no_err", 32'(err_at), 32'd0);
        chk("good_busy_low", 32'(key_busy[0]), 32'd0);
        send(0, 1'b0, 16'h0061, 16'h6162, 2'd0, "enc_a1");
        send(0, 1'b0, 16'h0061, 16'h6768, 2'd0, "enc_a2");

        // Invalid character gives err 1 without rotating the labels
        load(0, KEY_GOOD);
        wait_key(0, ok_at, err_at);
        chk("rekey_ok_at", 32'(ok_at), 32'd12);
        send(0, 1'b0, 16'h0061, 16'h6162, 2'd0, "enc_a");
        send(0, 1'b0, 16'h003F, 16'h0000, 2'd1, "enc_qmark");
        send(0, 1'b0, 16'h0062, 16'h6762, 2'd0, "enc_b");
        send(0, 1'b1, 16'h7879, 16'h0000, 2'd1, "dec_nolabel");

        // Non-alphanumeric key character fails at index 9
        load(0, KEY_BADC);
        wait_key(0, ok_at, err_at);
        chk("badc_err_at", 32'(err_at), 32'd10);
        chk("badc_ok", 32'(ok_at), 32'd0);
        @(negedge clk);
        chk("badc_err_pulse", 32'(key_err[0]), 32'd0);
        chk("badc_busy", 32'(key_busy[0]), 32'd0);
        send(0, 1'b0, 16'h0061, 16'h0000, 2'd2, "nokey_a");

        // Repeated key character fails at index 4, then a good key installs
        load(0, KEY_DUP);
        wait_key(0, ok_at, err_at);
        chk("dup_err_at", 32'(err_at), 32'd5);
        load(0, KEY_GOOD);
        wait_key(0, ok_at, err_at);
        chk("dup_then_ok_at", 32'(ok_at), 32'd12);
        send(0, 1'b0, 16'h0041, 16'h6162, 2'd0, "enc_upperA");

        // Full alphabet stream with random back-pressure
        for (int i = 0; i < 26; i++) stream[i]      = 8'(8'h61 + i);
        for (int i = 0; i < 26; i++) stream[26 + i] = 8'(8'h41 + i);
        for (int i = 0; i < 10; i++) stream[52 + i] = 8'(8'h30 + i);
        model_load(0, KEY_GOOD);
        load(0, KEY_GOOD);
        wait_key(0, ok_at, err_at);
        chk("stream_key_ok", 32'(ok_at), 32'd12);
        sent = 0; got = 0; cyc = 0; stall_prev = 1'b0; held = '0;
        while (((sent < 62) || (got < 62)) && (cyc < 2000)) begin
            out_ready[0] = 1'($urandom_range(0, 1));
            in_valid[0]  = (sent < 62);
            mode[0]      = 1'b0;
            in_data[0]   = {8'h00, stream[(sent < 62) ? sent : 61]};
            #1;
            if (stall_prev) chk("stream_hold", 32'(out_data[0]), 32'(held));
            if (out_valid[0] && out_ready[0]) begin
                if (expq.size() == 0) begin
                    chk("stream_extra", 32'd1, 32'd0);
                end else begin
                    chk("stream_data", 32'(out_data[0]), 32'(expq.pop_front()));
                    chk("stream_err", 32'(out_err[0]), 32'd0);
                end
                got++;
            end
            if (in_valid[0] && in_ready[0]) begin
                model_enc(0, stream[sent], e);
                expq.push_back(e);
                sent++;
            end
            stall_prev = out_valid[0] && !out_ready[0];
            held       = out_data[0];
            @(negedge clk);
            cyc++;
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        chk("stream_count", 32'(got), 32'd62);
        #1;
        chk("stream_drained", 32'(out_valid[0]), 32'd0);
        @(negedge clk);

        // Encrypt/decrypt round trips for both rotation steps
        round_trip(0, KEY_RT);
        round_trip(1, KEY_RT);

        // Reset in the middle of a key check
        load(0, KEY_GOOD);
        repeat (5) @(negedge clk);
        chk("midchk_busy", 32'(key_busy[0]), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("midchk_rst_busy", 32'(key_busy[0]), 32'd0);
        chk("midchk_rst_ok", 32'(key_ok[0]), 32'd0);
        chk("midchk_rst_err", 32'(key_err[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        send(0, 1'b0, 16'h0061, 16'h0000, 2'd2, "midchk_nokey");

        // Reset while an output beat is held by back-pressure
        load(0, KEY_GOOD);
        wait_key(0, ok_at, err_at);
        chk("pend_key_ok", 32'(ok_at), 32'd12);
        out_ready[0] = 1'b0;
        send(0, 1'b0, 16'h0061, 16'h6162, 2'd0, "pend_beat");
        chk("pend_in_ready", 32'(in_ready[0]), 32'd0);
        @(negedge clk);
        chk("pend_held_vld", 32'(out_valid[0]), 32'd1);
        chk("pend_held_data", 32'(out_data[0]), 32'h6162);
        #2;
        rst = 1'b1;
        #1;
        chk("pend_rst_vld", 32'(out_valid[0]), 32'd0);
        chk("pend_rst_data", 32'(out_data[0]), 32'd0);
        chk("pend_rst_err", 32'(out_err[0]), 32'd0);
        chk("pend_rst_ok", 32'(key_ok[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready[0] = 1'b1;
        #1;
        chk("pend_discarded", 32'(out_valid[0]), 32'd0);
        @(negedge clk);
        send(0, 1'b0, 16'h0061, 16'h0000, 2'd2, "pend_nokey");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
